// File: rtl/control_unit.sv
// control_unit: device-side channel control unit; every tag and bus_out is registered (1-cycle response)
// and each handshake state waits on the channel indefinitely unless CU_TIMEOUT_EN adds a 255-cycle watchdog.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  input  logic       operational_out,
  input  logic       select_out,
  input  logic       hold_out,
  input  logic       address_out,
  input  logic       command_out,
  input  logic       service_out,
  input  logic       suppress_out,
  output logic       operational_in,
  output logic       select_in,
  output logic       address_in,
  output logic       status_in,
  output logic       service_in,
  output logic       request_in,
  input  logic [7:0] address,
  output logic [7:0] command,
  output logic       command_strobe,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       rd_ready,
  input  logic       device_end,
`ifdef CU_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic       active
);

  typedef enum logic [3:0] {
    S_IDLE, S_OPER, S_ADDR_IN, S_CMD_WAIT, S_INIT_STATUS, S_INIT_DROP,
    S_DATA, S_SVC_IN, S_SVC_DROP, S_STOP_WAIT, S_END_STATUS, S_END_DROP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       op_q, op_d, sel_q, sel_d, addr_q, addr_d, stat_q, stat_d, svc_q, svc_d;
  logic [7:0] command_q, wr_data_q, init_status;
  logic       command_strobe_q, wr_strobe_q, rd_ready_q, end_pending_q;
  logic       latch_cmd, take_byte, is_write, is_read, in_data_phase;
  logic       unused_tags;

  assign is_write      = (command_q[1:0] == 2'b01);
  assign is_read       = (command_q[1:0] == 2'b10);
  assign in_data_phase = state_q inside {S_DATA, S_SVC_IN, S_SVC_DROP, S_STOP_WAIT, S_END_STATUS, S_END_DROP};
  assign unused_tags   = hold_out ^ suppress_out;

  always_comb begin
    init_status = 8'h00;
    if (command_q != 8'h00) begin
      case (command_q[1:0])
        2'b11:   init_status = 8'h30;
        2'b00:   init_status = 8'h70;
        default: init_status = 8'h00;
      endcase
    end
  end

`ifdef CU_TIMEOUT_EN
  logic [7:0] timer_q;
  logic       timeout_q, timeout_hit;

  assign timeout_hit = (state_q != S_IDLE) && (timer_q == 8'hFF);
  assign timeout     = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      timer_q   <= (state_d != state_q || state_q == S_IDLE) ? 8'h00 : timer_q + 8'd1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    take_byte = 1'b0;
    case (state_q)
      S_IDLE:        if (select_out && address_out && bus_in == address) state_d = S_OPER;
      S_OPER:        if (!address_out) state_d = S_ADDR_IN;
      S_ADDR_IN:     if (command_out) begin state_d = S_CMD_WAIT; latch_cmd = 1'b1; end
      S_CMD_WAIT:    if (!command_out) state_d = S_INIT_STATUS;
      S_INIT_STATUS: if (service_out) state_d = S_INIT_DROP;
      S_INIT_DROP:   if (!service_out) state_d = (init_status == 8'h00 && command_q != 8'h00) ? S_DATA : S_IDLE;
      S_DATA: begin
        if (end_pending_q) state_d = S_END_STATUS;
        else if (is_write || (is_read && rd_valid)) state_d = S_SVC_IN;
      end
      // A channel stop outranks a concurrent service acknowledge: no byte moves.
      S_SVC_IN: begin
        if (command_out) state_d = S_STOP_WAIT;
        else if (service_out) begin state_d = S_SVC_DROP; take_byte = 1'b1; end
      end
      S_SVC_DROP:    if (!service_out) state_d = S_DATA;
      S_STOP_WAIT:   if (!command_out) state_d = S_END_STATUS;
      S_END_STATUS:  if (service_out) state_d = S_END_DROP;
      S_END_DROP:    if (!service_out) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
`ifdef CU_TIMEOUT_EN
    if (timeout_hit) begin
      state_d   = S_IDLE;
      latch_cmd = 1'b0;
      take_byte = 1'b0;
    end
`endif
    // Selective reset keeps the latched command but abandons any transfer.
    if (!operational_out) begin
      state_d   = S_IDLE;
      latch_cmd = 1'b0;
      take_byte = 1'b0;
    end

    op_d   = (state_d != S_IDLE);
    addr_d = (state_d == S_ADDR_IN);
    stat_d = (state_d == S_INIT_STATUS) || (state_d == S_END_STATUS);
    svc_d  = (state_d == S_SVC_IN);
    // select_in stays up for the rest of a foreign selection once the address has missed.
    sel_d  = (state_d == S_IDLE) && operational_out && select_out &&
             (sel_q || (address_out && bus_in != address));

    case (state_d)
      S_ADDR_IN:     bus_out_d = address;
      S_INIT_STATUS: bus_out_d = init_status;
      S_END_STATUS:  bus_out_d = 8'h30;
      S_SVC_IN:      bus_out_d = (state_q == S_SVC_IN) ? bus_out_q : (is_read ? rd_data : 8'h00);
      default:       bus_out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      bus_out_q        <= 8'h00;
      op_q             <= 1'b0;
      sel_q            <= 1'b0;
      addr_q           <= 1'b0;
      stat_q           <= 1'b0;
      svc_q            <= 1'b0;
      command_q        <= 8'h00;
      command_strobe_q <= 1'b0;
      wr_data_q        <= 8'h00;
      wr_strobe_q      <= 1'b0;
      rd_ready_q       <= 1'b0;
      end_pending_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus_out_q        <= bus_out_d;
      op_q             <= op_d;
      sel_q            <= sel_d;
      addr_q           <= addr_d;
      stat_q           <= stat_d;
      svc_q            <= svc_d;
      command_strobe_q <= latch_cmd;
      if (latch_cmd) command_q <= bus_in;
      wr_strobe_q      <= take_byte && is_write;
      if (take_byte && is_write) wr_data_q <= bus_in;
      rd_ready_q       <= take_byte && is_read;
      if (state_d == S_IDLE) end_pending_q <= 1'b0;
      else if (device_end && in_data_phase) end_pending_q <= 1'b1;
    end
  end

  assign bus_out        = bus_out_q;
  assign operational_in = op_q;
  assign select_in      = sel_q;
  assign address_in     = addr_q;
  assign status_in      = stat_q;
  assign service_in     = svc_q;
  assign request_in     = 1'b0;
  assign command        = command_q;
  assign command_strobe = command_strobe_q;
  assign wr_data        = wr_data_q;
  assign wr_strobe      = wr_strobe_q;
  assign rd_ready       = rd_ready_q;
  assign active         = (state_q != S_IDLE);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: channel-side driver issues randomized selections; expected tag/bus events are queued
// from the protocol rules and matched by an independent monitor at each falling clock edge.
module tb_control_unit;
  localparam logic [7:0] DEV_ADDR = 8'h41;
  localparam int T_OP = 0, T_SEL = 1, T_ADDR = 2, T_STAT = 3, T_SVC = 4;

  logic       clk = 1'b0;
  logic       reset, operational_out, select_out, hold_out, address_out, command_out, service_out, suppress_out;
  logic       operational_in, select_in, address_in, status_in, service_in, request_in;
  logic [7:0] bus_in, bus_out, address, command, wr_data, rd_data;
  logic       command_strobe, wr_strobe, rd_valid, rd_ready, device_end, active;
`ifdef CU_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out),
    .operational_out(operational_out), .select_out(select_out), .hold_out(hold_out),
    .address_out(address_out), .command_out(command_out), .service_out(service_out),
    .suppress_out(suppress_out), .operational_in(operational_in), .select_in(select_in),
    .address_in(address_in), .status_in(status_in), .service_in(service_in),
    .request_in(request_in), .address(address), .command(command),
    .command_strobe(command_strobe), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .device_end(device_end),
`ifdef CU_TIMEOUT_EN
    .timeout(timeout),
`endif
    .active(active)
  );

  typedef enum int {EV_OPUP, EV_OPDROP, EV_ADDR, EV_CMD, EV_STAT, EV_SVC, EV_WR, EV_RD, EV_SELIN} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [7:0] val; } ev_t;
  ev_t        exp_q[$];
  int         errors = 0, checks = 0;
  logic [7:0] wplan [0:15];
  logic [7:0] rplan [0:15];

  // Initial status as a table of channel status bits: CE=0x10, DE=0x20, UC=0x40.
  function automatic logic [7:0] model_status(input logic [7:0] c);
    if (c == 8'h00) return 8'h00;
    if (c[1:0] == 2'b01 || c[1:0] == 2'b10) return 8'h00;
    if (c[1:0] == 2'b11) return 8'h10 | 8'h20;
    return 8'h10 | 8'h20 | 8'h40;
  endfunction

  function automatic logic tag(input int w);
    case (w)
      T_OP:    return operational_in;
      T_SEL:   return select_in;
      T_ADDR:  return address_in;
      T_STAT:  return status_in;
      default: return service_in;
    endcase
  endfunction

  task automatic push(input ev_kind_t k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic observe(input ev_kind_t k, input logic [7:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected %s val=%02h, none required", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("FAIL event: got %s val=%02h required %s val=%02h", k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  task automatic wait_tag(input string name, input int w, input logic v);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (tag(w) !== v && n < 80);
    checks++;
    if (tag(w) !== v) begin
      errors++;
      $display("FAIL wait_%s: tag=%b required %b within 80 cycles", name, tag(w), v);
    end
  endtask

  task automatic queue_empty(input string name);
    check({name, "_drained"}, 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  // Monitor: every rising tag, strobe or pulse must match the next queued expectation.
  initial begin
    logic op_p, ai_p, st_p, sv_p, si_p;
    op_p = 0; ai_p = 0; st_p = 0; sv_p = 0; si_p = 0;
    forever begin
      @(negedge clk);
      if (operational_in === 1'b1 && !op_p) observe(EV_OPUP, 8'h00);
      if (operational_in === 1'b0 && op_p)  observe(EV_OPDROP, 8'h00);
      if (address_in === 1'b1 && !ai_p)     observe(EV_ADDR, bus_out);
      if (command_strobe === 1'b1)          observe(EV_CMD, command);
      if (status_in === 1'b1 && !st_p)      observe(EV_STAT, bus_out);
      if (service_in === 1'b1 && !sv_p)     observe(EV_SVC, bus_out);
      if (wr_strobe === 1'b1)               observe(EV_WR, wr_data);
      if (rd_ready === 1'b1)                observe(EV_RD, 8'h00);
      if (select_in === 1'b1 && !si_p)      observe(EV_SELIN, 8'h00);
      op_p = (operational_in === 1'b1); ai_p = (address_in === 1'b1);
      st_p = (status_in === 1'b1); sv_p = (service_in === 1'b1); si_p = (select_in === 1'b1);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_txn(input logic [7:0] cmd);
    bus_in = DEV_ADDR; select_out = 1'b1; address_out = 1'b1;
    wait_tag("operational_in", T_OP, 1'b1);
    address_out = 1'b0; bus_in = 8'h00;
    wait_tag("address_in", T_ADDR, 1'b1);
    bus_in = cmd; command_out = 1'b1;
    wait_tag("address_in_drop", T_ADDR, 1'b0);
    command_out = 1'b0; bus_in = 8'h00;
    wait_tag("init_status", T_STAT, 1'b1);
    service_out = 1'b1;
    wait_tag("init_status_drop", T_STAT, 1'b0);
    service_out = 1'b0;
  endtask

  // nbytes bytes are exchanged; then either a channel stop (optionally with service_out) or device_end.
  task automatic run_cmd(input logic [7:0] cmd, input int nbytes, input bit by_stop, input bit stop_both);
    logic [7:0] st;
    bit         dphase, rd;
    int         gap;
    st     = model_status(cmd);
    dphase = (st == 8'h00) && (cmd != 8'h00);
    rd     = (cmd[1:0] == 2'b10);
    push(EV_OPUP, 8'h00); push(EV_ADDR, DEV_ADDR); push(EV_CMD, cmd); push(EV_STAT, st);
    if (dphase) begin
      for (int i = 0; i < nbytes; i++) begin
        push(EV_SVC, rd ? rplan[i] : 8'h00);
        if (rd) push(EV_RD, 8'h00); else push(EV_WR, wplan[i]);
      end
      if (by_stop) push(EV_SVC, rd ? rplan[nbytes] : 8'h00);
      push(EV_STAT, 8'h30);
    end
    push(EV_OPDROP, 8'h00);

    rd_data = rplan[0]; rd_valid = 1'b1;
    start_txn(cmd);
    if (dphase) begin
      for (int i = 0; i < nbytes; i++) begin
        wait_tag("service_in", T_SVC, 1'b1);
        bus_in = wplan[i]; service_out = 1'b1;
        wait_tag("service_in_drop", T_SVC, 1'b0);
        service_out = 1'b0; bus_in = 8'h00; rd_data = rplan[i+1];
        if (i == nbytes - 1 && !by_stop) device_end = 1'b1;
        gap = $urandom_range(0, 3);
        if (gap > 0) rd_valid = 1'b0;
        @(negedge clk);
        device_end = 1'b0;
        repeat (gap) @(negedge clk);
        rd_valid = 1'b1;
      end
      if (by_stop) begin
        wait_tag("service_in_stop", T_SVC, 1'b1);
        command_out = 1'b1; service_out = stop_both; bus_in = 8'hEE;
        wait_tag("service_in_stop_drop", T_SVC, 1'b0);
        command_out = 1'b0; service_out = 1'b0; bus_in = 8'h00;
      end
      wait_tag("end_status", T_STAT, 1'b1);
      service_out = 1'b1;
      wait_tag("end_status_drop", T_STAT, 1'b0);
      service_out = 1'b0;
    end
    wait_tag("operational_drop", T_OP, 1'b0);
    select_out = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    queue_empty("txn");
  endtask

  initial begin
    reset = 1'b1; operational_out = 1'b1; select_out = 1'b0; hold_out = 1'b0; address_out = 1'b0;
    command_out = 1'b0; service_out = 1'b0; suppress_out = 1'b0; bus_in = 8'h00; address = DEV_ADDR;
    rd_data = 8'h00; rd_valid = 1'b0; device_end = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus_out, command, wr_data, operational_in, select_in, address_in, status_in,
                            service_in, request_in, command_strobe, wr_strobe, rd_ready, active}, 40'd0);
    reset = 1'b0;
    @(negedge clk);

    wplan[0] = 8'h03; wplan[1] = 8'h02; wplan[2] = 8'h01; wplan[3] = 8'h00;
    run_cmd(8'h01, 3, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) rplan[i] = 8'hA5;
    run_cmd(8'h02, 2, 1'b0, 1'b0);
    check("command_retained", command, 8'h02);

    push(EV_SELIN, 8'h00);
    bus_in = 8'h42; select_out = 1'b1; address_out = 1'b1;
    wait_tag("select_in", T_SEL, 1'b1);
    repeat (3) @(negedge clk);
    check("mismatch_no_operational", operational_in, 1'b0);
    address_out = 1'b0; bus_in = 8'h00;
    repeat (2) @(negedge clk);
    check("mismatch_select_in_held", select_in, 1'b1);
    select_out = 1'b0;
    wait_tag("select_in_drop", T_SEL, 1'b0);
    queue_empty("mismatch");

    run_cmd(8'h04, 0, 1'b1, 1'b0);
    run_cmd(8'h00, 0, 1'b1, 1'b0);
    run_cmd(8'h03, 0, 1'b1, 1'b0);

    push(EV_OPUP, 8'h00); push(EV_ADDR, DEV_ADDR); push(EV_CMD, 8'h01); push(EV_STAT, 8'h00);
    push(EV_SVC, 8'h00); push(EV_WR, 8'h5A); push(EV_SVC, 8'h00); push(EV_OPDROP, 8'h00);
    start_txn(8'h01);
    wait_tag("service_in", T_SVC, 1'b1);
    bus_in = 8'h5A; service_out = 1'b1;
    wait_tag("service_in_drop", T_SVC, 1'b0);
    service_out = 1'b0; bus_in = 8'h00;
    wait_tag("service_in", T_SVC, 1'b1);
    operational_out = 1'b0; service_out = 1'b1; bus_in = 8'h77;
    @(negedge clk);
    check("selreset_tags", {operational_in, select_in, address_in, status_in, service_in, request_in,
                            bus_out, wr_strobe, active}, 40'd0);
    operational_out = 1'b1; service_out = 1'b0; select_out = 1'b0; bus_in = 8'h00;
    @(negedge clk);
    check("selreset_command_kept", command, 8'h01);
    queue_empty("selreset");

    push(EV_OPUP, 8'h00); push(EV_ADDR, DEV_ADDR); push(EV_CMD, 8'h02); push(EV_STAT, 8'h00);
    push(EV_SVC, 8'h3C); push(EV_OPDROP, 8'h00);
    rd_data = 8'h3C; rd_valid = 1'b1;
    start_txn(8'h02);
    wait_tag("service_in", T_SVC, 1'b1);
    reset = 1'b1; service_out = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {bus_out, command, wr_data, operational_in, select_in, address_in, status_in,
                               service_in, request_in, command_strobe, wr_strobe, rd_ready, active}, 40'd0);
    reset = 1'b0; service_out = 1'b0; select_out = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    queue_empty("midreset");

    for (int t = 0; t < 24; t++) begin
      logic [7:0] c;
      bit         stop;
      int         n;
      c = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       c[1:0] = 2'b01;
        1:       c[1:0] = 2'b10;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) c = 8'h00;
      for (int i = 0; i < 16; i++) begin
        wplan[i] = 8'($urandom);
        rplan[i] = 8'($urandom);
      end
      stop = 1'($urandom_range(0, 1));
      n    = $urandom_range(stop ? 0 : 1, 5);
      run_cmd(c, n, stop, 1'($urandom_range(0, 1)));
    end

`ifdef CU_TIMEOUT_EN
    push(EV_OPUP, 8'h00); push(EV_ADDR, DEV_ADDR); push(EV_CMD, 8'h01); push(EV_STAT, 8'h00);
    push(EV_SVC, 8'h00); push(EV_OPDROP, 8'h00);
    start_txn(8'h01);
    wait_tag("service_in", T_SVC, 1'b1);
    begin
      int n;
      n = 0;
      while (timeout !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("timeout_pulse", timeout, 1'b1);
    end
    @(negedge clk);
    check("timeout_idle", {active, timeout}, 2'b00);
    select_out = 1'b0;
    @(negedge clk);
    queue_empty("timeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 bus_in  in  8  channel 'bus out' (address, command, write data).
REQ-004 bus_out  out  8  to channel 'bus in' (address echo, status, read data).
REQ-005 operational_out, select_out, hold_out, address_out, command_out, service_out, suppress_out  in  1 each  channel outbound tags; suppress_out is ignored.
REQ-006 operational_in, select_in, address_in, status_in, service_in, request_in  out  1 each  inbound tags; request_in is held 0.
REQ-007 address  in  8  device address; static while active=0.
REQ-008 command / command_strobe  out  8/1  latched command byte; 1-cycle pulse on latch.
REQ-009 wr_data / wr_strobe  out  8/1  write byte; 1-cycle pulse per accepted byte.
REQ-010 rd_data / rd_valid / rd_ready  in/in/out  8/1/1  read source; rd_ready pulses 1 cycle per byte taken.
REQ-011 device_end  in  1  pulse requesting end of data transfer.
REQ-012 active  out  1  high when state != IDLE.

Function
REQ-013 All tag outputs and bus_out are registered and respond 1 cycle after the qualifying input; bus_out=0 when no state drives it.
REQ-014 Status bit map: CE=bit4 (0x10), DE=bit5 (0x20), UC=bit6 (0x40).
REQ-015 IDLE: select_out & address_out & bus_in==address -> OPER (operational_in=1); select_out & address mismatch -> select_in=1 while select_out stays high.
REQ-016 OPER: wait !address_out -> ADDR_IN (operational_in, address_in, bus_out=address).
REQ-017 ADDR_IN: command_out -> latch bus_in to command, pulse command_strobe, drop address_in -> CMD_WAIT.
REQ-018 CMD_WAIT: wait !command_out -> INIT_STATUS (status_in=1, bus_out = initial status).
REQ-019 Initial status: 0x00 for command==0x00 (test I/O), cmd[1:0]=01 (write) and 10 (read); 0x30 for 11 (control); 0x70 for any other command with cmd[1:0]=00.
REQ-020 INIT_STATUS: service_out -> drop status_in -> INIT_DROP; on !service_out: status==0 & command!=0 -> DATA, else -> IDLE with operational_in dropped.
REQ-021 DATA: end_pending -> END_STATUS; else write, or read with rd_valid -> SVC_IN (service_in=1; bus_out=rd_data when reading, else 0).
REQ-022 SVC_IN: service_out -> pulse wr_strobe with wr_data=bus_in (write) or pulse rd_ready (read); drop service_in -> SVC_DROP; wait !service_out -> DATA.
REQ-023 SVC_IN with command_out (channel stop) -> drop service_in, no byte transferred; wait !command_out -> END_STATUS.
REQ-024 If service_out and command_out are both high in SVC_IN, command_out wins.
REQ-025 device_end sets end_pending in any state from DATA onward; an in-flight byte completes first; end_pending clears on IDLE entry.
REQ-026 END_STATUS: status_in=1, bus_out=0x30; service_out -> drop status_in; wait !service_out -> IDLE, operational_in dropped.
REQ-027 operational_out low in any state -> IDLE next cycle with all tags low (selective reset); command is retained.

Reset
REQ-028 reset forces IDLE; all tags, bus_out, command, wr_data and strobes are 0; end_pending is cleared; reset mid-transfer aborts without strobes.

Configuration
REQ-029 CU_TIMEOUT_EN defined: an 8-bit timer restarts on each state change; reaching 255 cycles in any non-IDLE wait state -> IDLE, tags dropped, 1-cycle timeout output pulse.
REQ-030 CU_TIMEOUT_EN undefined: no timer and no timeout port; wait states hold indefinitely.

Verification
REQ-031 address=0x41; select with bus 0x41, command 0x01, three service cycles with bus 0x03,0x02,0x01, then stop -> wr_strobe x3 with bytes 03,02,01; end status 0x30.
REQ-032 Read 0x02, rd_data=0xA5 valid, device_end after 2 bytes -> two rd_ready pulses; end status 0x30; operational_in drops.
REQ-033 Select with bus 0x42 while address=0x41 -> select_in=1, operational_in stays 0.
REQ-034 Command 0x04 -> initial status 0x70; return to IDLE after service_out falls.
REQ-035 operational_out dropped in SVC_IN -> all tags 0 next cycle, no strobe.
REQ-036 With CU_TIMEOUT_EN: hold service_out low for 255 cycles in SVC_IN -> timeout pulse; state IDLE.
